// File: rtl/clk_src_mux_gate_pkg.sv
// Shared configuration-word layout for the clock source selector/gate.
package clk_src_mux_gate_pkg;

    localparam int SEL_LSB = 0;
    localparam int SEL_MSB = 3;
    localparam int EN_BIT  = 4;
    localparam int INV_BIT = 5;

    localparam logic [5:0] CFG_RST = 6'h00;

endpackage

// File: rtl/clk_gate_latch.sv
// Glitch-free clock gate: enable latch transparent while mclk is low, output NAND/INV.
module clk_gate_latch (
    input  logic mclk,
    input  logic cenb,
    input  logic rst_n,
    output logic gclk,
    output logic gclkb
);

    // clat is the latched active-low enable; 1 means the clock is blocked.
    logic clat;

    always_latch begin
        if (!rst_n) begin
            clat <= 1'b1;
        end else if (!mclk) begin
            clat <= cenb;
        end
    end

    assign gclkb = ~(mclk & ~clat);
    assign gclk  = ~gclkb;

endmodule

// File: rtl/clk_src_mux_gate.sv
// Configurable clock source select (12 nets), optional inversion and latch-based gating.
module clk_src_mux_gate
    import clk_src_mux_gate_pkg::*;
#(
    parameter int NSRC  = 12,
    parameter int CFG_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             prog,
    input  logic             cfg_we,
    input  logic [CFG_W-1:0] cfg_wdata,
    output logic [CFG_W-1:0] cfg_rdata,
    input  logic [NSRC-1:0]  min,
    input  logic             cenb,
    output logic             gclk,
    output logic             gclkb
);

    logic [CFG_W-1:0] cfg_q;
    logic [CFG_W-1:0] cfg_d;
    logic [3:0]       sel;
    logic             src;
    logic             clkm;
    logic             inv_sel;
    logic             mclk;

    // Configuration only accepts writes while in programming mode.
    always_comb begin
        cfg_d = cfg_q;
        if (prog && cfg_we) begin
            cfg_d = cfg_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_q <= CFG_RST;
        end else begin
            cfg_q <= cfg_d;
        end
    end

    assign cfg_rdata = cfg_q;
    assign sel       = cfg_q[SEL_MSB:SEL_LSB];

    // Codes 12..15 select nothing and hold the source low.
    always_comb begin
        src = 1'b0;
        if (!sel[3]) begin
            src = min[{1'b0, sel[2:0]}];
        end else if (!sel[2]) begin
            src = min[{2'b10, sel[1:0]}];
        end
    end

    assign clkm    = src & cfg_q[EN_BIT] & ~prog;
    assign inv_sel = cfg_q[INV_BIT] & cfg_q[EN_BIT] & ~prog;
    assign mclk    = inv_sel ? ~clkm : clkm;

    clk_gate_latch u_gate (
        .mclk  (mclk),
        .cenb  (cenb),
        .rst_n (rst_n),
        .gclk  (gclk),
        .gclkb (gclkb)
    );

endmodule

// File: tb/tb_clk_src_mux_gate.sv
// Self-checking bench for clk_src_mux_gate: spec-level model feeds a scoreboard queue.
module tb_clk_src_mux_gate;

    logic        clk;
    logic        rst_n;
    logic        prog;
    logic        cfg_we;
    logic [5:0]  cfg_wdata;
    logic [5:0]  cfg_rdata;
    logic [11:0] min;
    logic        cenb;
    logic        gclk;
    logic        gclkb;

    clk_src_mux_gate dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .prog      (prog),
        .cfg_we    (cfg_we),
        .cfg_wdata (cfg_wdata),
        .cfg_rdata (cfg_rdata),
        .min       (min),
        .cenb      (cenb),
        .gclk      (gclk),
        .gclkb     (gclkb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [7:0] exp;
    } sb_t;

    sb_t        sb[$];
    int         n_chk = 0;
    int         n_bad = 0;
    logic [5:0] m_cfg;
    logic       m_clat;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got {cfg,gclk,gclkb}=%b want %b", tag, obs, exp);
        end
    endtask

    // Reference selection straight from the behavioural description.
    function automatic logic f_mclk(input logic [5:0] c, input logic [11:0] m, input logic p);
        logic s;
        int   idx;
        s = 1'b0;
        if (c[3] == 1'b0) begin
            idx = int'(c[2:0]);
            s   = m[idx];
        end else if (c[2] == 1'b0) begin
            idx = 8 + int'(c[1:0]);
            s   = m[idx];
        end
        if (c[4] && !p) return s ^ c[5];
        return 1'b0;
    endfunction

    task automatic push_exp(input string tag);
        logic mc;
        sb_t  it;
        if (!rst_n) begin
            m_cfg  = 6'h00;
            m_clat = 1'b1;
        end
        mc = f_mclk(m_cfg, min, prog);
        if (rst_n && !mc) m_clat = cenb;
        it.tag = tag;
        it.exp = {m_cfg, mc & ~m_clat, ~(mc & ~m_clat)};
        sb.push_back(it);
    endtask

    task automatic pop_cmp();
        sb_t it;
        if (sb.size() == 0) begin
            n_chk++;
            n_bad++;
            $display("FAIL sb_empty: got size=0 want >0");
        end else begin
            it = sb.pop_front();
            chk(it.tag, {cfg_rdata, gclk, gclkb}, it.exp);
        end
    endtask

    task automatic step(input string tag);
        #1;
        push_exp(tag);
        #1;
        pop_cmp();
    endtask

    task automatic write_cfg(input logic [5:0] w, input logic p, input string tag);
        @(negedge clk);
        prog      = p;
        cfg_we    = 1'b1;
        cfg_wdata = w;
        @(posedge clk);
        if (p && rst_n) m_cfg = w;
        #1;
        cfg_we = 1'b0;
        step(tag);
    endtask

    // Direct gclk check against a hand-derived constant.
    task automatic step_g(input string tag, input logic g);
        step(tag);
        chk({tag, "_g"}, {6'd0, gclk, gclkb}, {6'd0, g, ~g});
    endtask

    initial begin
        rst_n     = 1'b0;
        prog      = 1'b0;
        cfg_we    = 1'b0;
        cfg_wdata = 6'h00;
        min       = 12'h000;
        cenb      = 1'b0;
        m_cfg     = 6'h00;
        m_clat    = 1'b1;

        // Reset with sources toggling.
        for (int i = 0; i < 4; i++) begin
            min = 12'($urandom);
            step("rst_hold");
            min = ~min;
            step("rst_toggle");
        end
        @(negedge clk);
        rst_n = 1'b1;
        step("rst_release");
        min = 12'hFFF;
        step("post_rst_min_hi");

        // Write ignored outside programming mode.
        write_cfg(6'b010101, 1'b0, "wr_noprog");
        chk("wr_noprog_rd", {cfg_rdata, 2'b00}, 8'h00);

        // Select 5, enabled.
        write_cfg(6'b010101, 1'b1, "wr_sel5");
        prog = 1'b0;
        cenb = 1'b0;
        for (int i = 0; i < 6; i++) begin
            min = 12'($urandom);
            min[5] = i[0];
            step("sel5_follow");
        end

        // Select 10, enabled, inverted.
        write_cfg(6'b111010, 1'b1, "wr_sel10_inv");
        prog = 1'b0;
        for (int i = 0; i < 6; i++) begin
            min = 12'($urandom);
            min[10] = i[0];
            step("sel10_inv");
        end

        // Unused code 12.
        write_cfg(6'b011100, 1'b1, "wr_code12");
        prog = 1'b0;
        for (int i = 0; i < 4; i++) begin
            min = 12'($urandom);
            step_g("code12", 1'b0);
        end

        // Gating on min[0].
        write_cfg(6'b010000, 1'b1, "wr_sel0");
        prog = 1'b0;
        cenb = 1'b0;
        min  = 12'h000;
        step_g("gate_lo0", 1'b0);
        min[0] = 1'b1;
        step_g("gate_hi0", 1'b1);
        cenb = 1'b1;
        step_g("cenb_rise_midhi", 1'b1);
        min[0] = 1'b0;
        step_g("pulse_done", 1'b0);
        min[0] = 1'b1;
        step_g("blocked_hi", 1'b0);
        cenb = 1'b0;
        step_g("cenb_fall_midhi", 1'b0);
        min[0] = 1'b0;
        step_g("reenable_lo", 1'b0);
        min[0] = 1'b1;
        step_g("reenable_hi", 1'b1);

        // Programming mode kills the clock at once and allows writes.
        prog = 1'b1;
        step_g("prog_kill", 1'b0);
        write_cfg(6'b010101, 1'b1, "wr_in_prog");
        min = 12'h020;
        step_g("prog_hold_low", 1'b0);
        prog = 1'b0;
        step_g("prog_resume", 1'b1);

        // Async reset mid-pulse, away from any clk edge.
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        step_g("async_rst", 1'b0);
        chk("async_rst_cfg", {cfg_rdata, 2'b00}, 8'h00);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
